counter_seq_ctrl: RTL and testbench
===================================

COUNTER_SEQ_CTRL -- requirements
Module: counter_seq_ctrl

Interface
REQ-001 Parameter: W, default 8, width of the count and configuration values.
REQ-002 Parameter: DIV_W, default 8, width of the prescaler divide value.
REQ-003 Port: clk  in  1  single clock; all logic is on the rising edge.
REQ-004 Port: rst  in  1  reset; one clock; reset is synchronous and active-high.
REQ-005 Port: start  in  1  one-cycle request to begin a sweep; ignored while busy=1.
REQ-006 Port: abort  in  1  return to IDLE; no done pulse.
REQ-007 Port: pause  in  1  level; while 1 in RUN, prescaler and count stepping freeze.
REQ-008 Port: cfg_start  in  W  sweep origin value.
REQ-009 Port: cfg_end  in  W  sweep target value.
REQ-010 Port: cfg_div  in  DIV_W  one step every cfg_div+1 RUN cycles.
REQ-011 Port: cfg_pingpong  in  1  1 = bounce between origin and target.
REQ-012 Port: cfg_legs  in  4  ping-pong leg limit; 0 = unlimited.
REQ-013 Port: count_in  in  W  current value fed back from the controlled counter.
REQ-014 Port: cnt_en  out  1  counter step enable.
REQ-015 Port: cnt_dir  out  1  1 = up, 0 = down.
REQ-016 Port: cnt_load  out  1  synchronous load strobe; load_val is the value loaded.
REQ-017 Port: load_val  out  W  value to load.
REQ-018 Port: cnt_oe  out  1  bus drive enable; equals busy.
REQ-019 Port: busy  out  1  high in LOAD, RUN and DONE.
REQ-020 Port: done  out  1  one-cycle pulse at sweep completion.

Function
REQ-021 States SHALL be IDLE, LOAD, RUN and DONE.
REQ-022 IDLE: when start=1, capture all cfg_* values into shadow registers and go to LOAD; cfg_* changes after capture SHALL have no effect.
REQ-023 LOAD: for exactly one cycle, cnt_load=1 and load_val=origin; clear the prescaler and leg counter; go to RUN.
REQ-024 Leg direction: target>count origin -> cnt_dir=1; otherwise cnt_dir=0 (unsigned compare); the counter SHALL never wrap.
REQ-025 RUN: tick SHALL be 1 when prescaler==div; the prescaler counts 0..div and then wraps to 0.
REQ-026 RUN: cnt_en SHALL equal tick & !pause & (count_in!=target), combinationally.
REQ-027 RUN with count_in==target, non-ping-pong or leg limit reached: go to DONE.
REQ-028 RUN with count_in==target, ping-pong and limit not reached: swap origin and target, invert cnt_dir, increment the leg counter, clear the prescaler, and stay in RUN.
REQ-029 DONE: done=1 for one cycle, then go to IDLE.
REQ-030 cfg_start==cfg_end: DONE on the first RUN cycle with zero cnt_en pulses, including when ping-pong is set (any cfg_legs).
REQ-031 abort in any state: next state IDLE, all outputs 0, no done; abort wins over a simultaneous start.
REQ-032 When only cnt_load is active, load_val SHALL equal the origin; otherwise load_val SHALL equal 0.

Reset
REQ-033 rst=1 SHALL force IDLE, clear the prescaler, leg counter and shadow registers, and drive all outputs to 0 on the next edge; this applies mid-sweep as well.

Structure
REQ-034 Package counter_seq_pkg SHALL hold the state enum and the default values of W and DIV_W.
REQ-035 The prescaler SHALL be sub-module tick_gen (inputs clear, hold, div; output tick).
REQ-036 Total RTL size SHALL be 120-400 lines.

Verification
REQ-037 Bench pairs the block with the 8-bit counter (ena=1); cfg 3->6, div=0, no ping-pong, start sampled at cycle 0 -> cnt_load at cycle 1, cnt_en at cycles 2-4, count 6, done at cycle 6, IDLE at cycle 7.
REQ-038 Down sweep 200->197, div=3 -> cnt_dir=0, a step every 4 cycles, 3 steps total, then done; never wraps.
REQ-039 Ping-pong 10<->12, legs=3 -> count sequence 10,11,12,11,10,11,12 then done; cnt_dir toggles at 12 and at 10.
REQ-040 pause held for 5 cycles mid-RUN -> count_in and the prescaler remain frozen; stepping resumes at the same phase when pause is released.
REQ-041 abort and rst each asserted mid-RUN -> outputs 0 next cycle, no done; start pulsed while busy -> ignored.
REQ-042 cfg_start==cfg_end==0x80 -> cnt_load pulse, then done, with zero cnt_en pulses.

Source files
------------

// File: rtl/counter_seq_pkg.sv
// Shared types and default widths for the counter sweep sequencer.
package counter_seq_pkg;

  localparam int unsigned W_DEFAULT     = 8;
  localparam int unsigned DIV_W_DEFAULT = 8;
  localparam int unsigned LEGS_W        = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/counter_seq_ctrl_tick_gen.sv
// Prescaler: counts 0..div and flags the terminal value as the step tick.
module tick_gen
  import counter_seq_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             hold,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (!hold) begin
      if (r_cnt >= div) r_cnt <= '0;
      else              r_cnt <= r_cnt + DIV_W'(1);
    end
  end

  assign tick = (r_cnt == div);

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sweep sequencer driving an external up/down counter between two captured values.
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int unsigned W     = W_DEFAULT,
  parameter int unsigned DIV_W = DIV_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              pause,
  input  logic [W-1:0]      cfg_start,
  input  logic [W-1:0]      cfg_end,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_pingpong,
  input  logic [LEGS_W-1:0] cfg_legs,
  input  logic [W-1:0]      count_in,
  output logic              cnt_en,
  output logic              cnt_dir,
  output logic              cnt_load,
  output logic [W-1:0]      load_val,
  output logic              cnt_oe,
  output logic              busy,
  output logic              done
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [W-1:0]        r_origin;
  logic [W-1:0]        r_target;
  logic [DIV_W-1:0]    r_div;
  logic                r_pingpong;
  logic [LEGS_W-1:0]   r_legs;
  logic [LEGS_W-1:0]   r_leg_cnt;

  logic w_capture;
  logic w_swap;
  logic w_presc_clr;
  logic w_presc_hold;
  logic w_tick;
  logic w_up;
  logic w_at_target;
  logic w_limit;

  assign w_up        = (r_target > r_origin);
  assign w_at_target = (count_in == r_target);
  assign w_limit     = (r_legs != '0) && (r_leg_cnt == r_legs - LEGS_W'(1));

  tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (w_presc_clr),
    .hold  (w_presc_hold),
    .div   (r_div),
    .tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Shadow configuration and leg bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_origin   <= '0;
      r_target   <= '0;
      r_div      <= '0;
      r_pingpong <= 1'b0;
      r_legs     <= '0;
      r_leg_cnt  <= '0;
    end else begin
      if (w_capture) begin
        r_origin   <= cfg_start;
        r_target   <= cfg_end;
        r_div      <= cfg_div;
        r_pingpong <= cfg_pingpong;
        r_legs     <= cfg_legs;
      end
      if (r_state == ST_LOAD) begin
        r_leg_cnt <= '0;
      end
      if (w_swap) begin
        r_origin  <= r_target;
        r_target  <= r_origin;
        r_leg_cnt <= r_leg_cnt + LEGS_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_capture    = 1'b0;
    w_swap       = 1'b0;
    w_presc_clr  = 1'b1;
    w_presc_hold = 1'b0;
    cnt_en       = 1'b0;
    cnt_dir      = 1'b0;
    cnt_load     = 1'b0;
    load_val     = '0;
    busy         = 1'b0;
    done         = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_load    = 1'b1;
        load_val    = r_origin;
        busy        = 1'b1;
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy         = 1'b1;
        cnt_dir      = w_up;
        w_presc_clr  = 1'b0;
        w_presc_hold = pause;
        if (w_at_target) begin
          // A degenerate sweep (origin == target) finishes even in ping-pong mode
          if (!r_pingpong || w_limit || (r_origin == r_target)) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_swap      = 1'b1;
            w_presc_clr = 1'b1;
          end
        end else begin
          cnt_en = w_tick & ~pause;
        end
      end
      ST_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Abort overrides everything, including a start seen in the same cycle
    if (abort) begin
      w_state_nxt  = ST_IDLE;
      w_capture    = 1'b0;
      w_swap       = 1'b0;
      w_presc_clr  = 1'b1;
      w_presc_hold = 1'b0;
      cnt_en       = 1'b0;
      cnt_dir      = 1'b0;
      cnt_load     = 1'b0;
      load_val     = '0;
      busy         = 1'b0;
      done         = 1'b0;
    end
  end

  assign cnt_oe = busy;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Scoreboard bench: sequencer paired with an 8-bit up/down counter model.
module tb_counter_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       pause = 1'b0;
  logic [7:0] cfg_start = 8'd0;
  logic [7:0] cfg_end = 8'd0;
  logic [7:0] cfg_div = 8'd0;
  logic       cfg_pingpong = 1'b0;
  logic [3:0] cfg_legs = 4'd0;
  logic [7:0] r_count;
  logic       cnt_en, cnt_dir, cnt_load, cnt_oe, busy, done;
  logic [7:0] load_val;

  int r_cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    string      name;
    int         kind;   // 0 load, 1 step, 2 done
    int         cyc;
    logic [7:0] val;
    logic       dir;
  } ev_t;

  typedef struct {
    string       name;
    int          cyc;
    logic [20:0] v;     // busy,oe,en,load,done,load_val,count
  } snap_t;

  ev_t   ev_q[$];
  snap_t snap_q[$];

  counter_seq_ctrl #(.W(8), .DIV_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .pause        (pause),
    .cfg_start    (cfg_start),
    .cfg_end      (cfg_end),
    .cfg_div      (cfg_div),
    .cfg_pingpong (cfg_pingpong),
    .cfg_legs     (cfg_legs),
    .count_in     (r_count),
    .cnt_en       (cnt_en),
    .cnt_dir      (cnt_dir),
    .cnt_load     (cnt_load),
    .load_val     (load_val),
    .cnt_oe       (cnt_oe),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) r_cyc <= r_cyc + 1;

  // Controlled counter, permanently enabled
  always @(posedge clk) begin
    if (rst)           r_count <= 8'd0;
    else if (cnt_load) r_count <= load_val;
    else if (cnt_en)   r_count <= cnt_dir ? r_count + 8'd1 : r_count - 8'd1;
  end

  // Monitor: compare DUT activity and state snapshots against the queues
  always @(negedge clk) begin
    logic [20:0] act;
    int          kind;
    logic [7:0]  val;
    ev_t         e;
    snap_t       s;
    if (ev_q.size() > 0 && ev_q[0].cyc < r_cyc) begin
      e = ev_q.pop_front();
      n_checks = n_checks + 1;
      n_fail = n_fail + 1;
      $display("FAIL %s: no event seen, expected kind=%0d at cyc=%0d val=%0h", e.name, e.kind, e.cyc, e.val);
    end
    if (cnt_load || cnt_en || done) begin
      kind = cnt_load ? 0 : (done ? 2 : 1);
      val  = cnt_load ? load_val : r_count;
      n_checks = n_checks + 1;
      if (ev_q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL unexpected: got kind=%0d cyc=%0d val=%0h dir=%0b, required no activity", kind, r_cyc, val, cnt_dir);
      end else begin
        e = ev_q.pop_front();
        if ((32'(int'(cnt_load) + int'(cnt_en) + int'(done)) != 32'd1) || kind != e.kind || r_cyc != e.cyc ||
            val != e.val || (kind == 1 && cnt_dir != e.dir)) begin
          n_fail = n_fail + 1;
          $display("FAIL %s: got kind=%0d cyc=%0d val=%0h dir=%0b, expected kind=%0d cyc=%0d val=%0h dir=%0b",
                   e.name, kind, r_cyc, val, cnt_dir, e.kind, e.cyc, e.val, e.dir);
        end
      end
    end
    if (snap_q.size() > 0 && snap_q[0].cyc <= r_cyc) begin
      s = snap_q.pop_front();
      act = {busy, cnt_oe, cnt_en, cnt_load, done, load_val, r_count};
      n_checks = n_checks + 1;
      if (act !== s.v || s.cyc != r_cyc) begin
        n_fail = n_fail + 1;
        $display("FAIL %s: got %06h at cyc=%0d, expected %06h at cyc=%0d", s.name, act, r_cyc, s.v, s.cyc);
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  function automatic void push_ev(input string name, input int kind, input int cyc,
                                  input logic [7:0] val, input logic dir);
    ev_t e;
    e.name = name; e.kind = kind; e.cyc = cyc; e.val = val; e.dir = dir;
    ev_q.push_back(e);
  endfunction

  function automatic void push_snap(input string name, input int cyc, input logic bsy,
                                    input logic en, input logic ld, input logic dn,
                                    input logic [7:0] lv, input logic [7:0] cnt);
    snap_t s;
    s.name = name; s.cyc = cyc; s.v = {bsy, bsy, en, ld, dn, lv, cnt};
    snap_q.push_back(s);
  endfunction

  task automatic set_cfg(input logic [7:0] s, input logic [7:0] e, input logic [7:0] d,
                         input logic pp, input logic [3:0] legs);
    cfg_start = s; cfg_end = e; cfg_div = d; cfg_pingpong = pp; cfg_legs = legs;
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (ev_q.size() == 0 && snap_q.size() == 0) break;
      wait_cyc(1);
    end
    wait_cyc(2);
  endtask

  initial begin
    int t0;

    // Reset state
    wait_cyc(2);
    push_snap("reset", r_cyc, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(2);

    // Up sweep 3->6, div 0
    t0 = r_cyc;
    push_ev("up_load", 0, t0 + 1, 8'd3, 1'b0);
    for (int k = 0; k < 3; k++) push_ev("up_step", 1, t0 + 2 + k, 8'(3 + k), 1'b1);
    push_ev("up_done", 2, t0 + 6, 8'd6, 1'b0);
    push_snap("up_idle", t0 + 7, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd6);
    set_cfg(8'd3, 8'd6, 8'd0, 1'b0, 4'd0);
    start = 1'b1;
    wait_cyc(1);
    start = 1'b0;
    drain();

    // Down sweep 200->197, div 3
    t0 = r_cyc;
    push_ev("down_load", 0, t0 + 1, 8'd200, 1'b0);
    for (int k = 0; k < 3; k++) push_ev("down_step", 1, t0 + 5 + 4 * k, 8'(200 - k), 1'b0);
    push_ev("down_done", 2, t0 + 15, 8'd197, 1'b0);
    set_cfg(8'd200, 8'd197, 8'd3, 1'b0, 4'd0);
    start = 1'b1;
    wait_cyc(1);
    start = 1'b0;
    drain();

    // Ping-pong 10<->12, three legs
    t0 = r_cyc;
    push_ev("pp_load", 0, t0 + 1, 8'd10, 1'b0);
    push_ev("pp_step", 1, t0 + 2, 8'd10, 1'b1);
    push_ev("pp_step", 1, t0 + 3, 8'd11, 1'b1);
    push_ev("pp_step", 1, t0 + 5, 8'd12, 1'b0);
    push_ev("pp_step", 1, t0 + 6, 8'd11, 1'b0);
    push_ev("pp_step", 1, t0 + 8, 8'd10, 1'b1);
    push_ev("pp_step", 1, t0 + 9, 8'd11, 1'b1);
    push_ev("pp_done", 2, t0 + 11, 8'd12, 1'b0);
    set_cfg(8'd10, 8'd12, 8'd0, 1'b1, 4'd3);
    start = 1'b1;
    wait_cyc(1);
    start = 1'b0;
    drain();

    // Pause for five cycles mid-RUN, div 1
    t0 = r_cyc;
    push_ev("pause_load", 0, t0 + 1, 8'd50, 1'b0);
    push_ev("pause_step", 1, t0 + 3, 8'd50, 1'b1);
    push_ev("pause_step", 1, t0 + 5, 8'd51, 1'b1);
    for (int k = 0; k < 8; k++) push_ev("pause_resume", 1, t0 + 12 + 2 * k, 8'(52 + k), 1'b1);
    push_ev("pause_done", 2, t0 + 28, 8'd60, 1'b0);
    push_snap("pause_frozen", t0 + 10, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'd52);
    set_cfg(8'd50, 8'd60, 8'd1, 1'b0, 4'd0);
    start = 1'b1;
    wait_cyc(1);
    start = 1'b0;
    wait_cyc(5);
    pause = 1'b1;
    wait_cyc(5);
    pause = 1'b0;
    drain();

    // Start while busy is ignored, then abort mid-RUN
    t0 = r_cyc;
    push_ev("abort_load", 0, t0 + 1, 8'd20, 1'b0);
    for (int k = 0; k < 3; k++) push_ev("abort_step", 1, t0 + 2 + k, 8'(20 + k), 1'b1);
    push_snap("abort_idle", t0 + 6, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd23);
    set_cfg(8'd20, 8'd40, 8'd0, 1'b0, 4'd0);
    start = 1'b1;
    wait_cyc(1);
    start = 1'b0;
    wait_cyc(2);
    set_cfg(8'd99, 8'd0, 8'd0, 1'b0, 4'd0);
    start = 1'b1;
    wait_cyc(1);
    start = 1'b0;
    wait_cyc(1);
    abort = 1'b1;
    wait_cyc(1);
    abort = 1'b0;
    drain();

    // Abort beats a simultaneous start
    t0 = r_cyc;
    push_snap("abort_vs_start", t0 + 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'd23);
    set_cfg(8'd1, 8'd5, 8'd0, 1'b0, 4'd0);
    start = 1'b1;
    abort = 1'b1;
    wait_cyc(1);
    start = 1'b0;
    abort = 1'b0;
    drain();

    // Reset mid-RUN
    t0 = r_cyc;
    push_ev("rst_load", 0, t0 + 1, 8'h30, 1'b0);
    for (int k = 0; k < 3; k++) push_ev("rst_step", 1, t0 + 2 + k, 8'(8'h30 + k), 1'b1);
    push_snap("rst_idle", t0 + 5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_cfg(8'h30, 8'h40, 8'd0, 1'b0, 4'd0);
    start = 1'b1;
    wait_cyc(1);
    start = 1'b0;
    wait_cyc(3);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    drain();

    // Degenerate sweep origin == target in ping-pong mode
    t0 = r_cyc;
    push_ev("equal_load", 0, t0 + 1, 8'h80, 1'b0);
    push_ev("equal_done", 2, t0 + 3, 8'h80, 1'b0);
    push_snap("equal_idle", t0 + 4, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h80);
    set_cfg(8'h80, 8'h80, 8'd5, 1'b1, 4'd0);
    start = 1'b1;
    wait_cyc(1);
    start = 1'b0;
    drain();
    wait_cyc(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
